// File: rtl/line_window_3x3_pkg.sv
// Shared image-pipeline constants and window indexing helpers.
package line_window_3x3_pkg;
    localparam int DATA_W    = 10;
    localparam int MAX_WIDTH = 1280;
    localparam int ADDR_W    = 11;
    localparam int WIN_W     = 9 * DATA_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Bit offset of window element (r, c); r0 = two lines up, c2 = newest column.
    function automatic int win_idx(input int r, input int c);
        return (r * 3 + c) * DATA_W;
    endfunction
endpackage

// File: rtl/line_window_3x3_if.sv
// Pixel-in / window-out bundle between capture, window builder and edge stage.
interface line_window_3x3_if;
    import line_window_3x3_pkg::*;

    logic              iFVAL;
    logic              iDVAL;
    logic [DATA_W-1:0] iDATA;
    logic [WIN_W-1:0]  oWIN;
    logic              oDVAL;
    logic              oBORDER;
    logic              oOVF;

    modport slave  (input  iFVAL, iDVAL, iDATA, output oWIN, oDVAL, oBORDER, oOVF);
    modport master (output iFVAL, iDVAL, iDATA, input  oWIN, oDVAL, oBORDER, oOVF);
endinterface

// File: rtl/line_window_3x3_ram.sv
// Single-clock line RAM: one write port, one registered read port.
// A same-address read and write in one cycle returns the old contents.
module line_ram_2p #(
    parameter int DW    = 10,
    parameter int DEPTH = 1280,
    parameter int AW    = 11
) (
    input  logic          iCLK,
    input  logic          i_wen,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_rden,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Write port; contents deliberately survive reset.
    always_ff @(posedge iCLK)
        if (i_wen) r_mem[i_waddr] <= i_wdata;

    // Registered read; nonblocking update gives old-data on collision.
    always_ff @(posedge iCLK)
        if (i_rden) r_rdata <= r_mem[i_raddr];

    assign o_rdata = r_rdata;
endmodule

// File: rtl/line_window_3x3.sv
// Raster stream -> 3x3 window for the Sobel stage, with border and overflow flags.
module line_window_3x3
    import line_window_3x3_pkg::*;
(
    input  logic              iCLK,
    input  logic              iRST_N,
    line_window_3x3_if.slave  bus
);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(MAX_WIDTH - 1);

    state_t              r_state, w_state_nxt;
    logic [ADDR_W-1:0]   r_col, r_col_d1;
    logic                r_full;
    logic [1:0]          r_row;
    logic                r_ovf;
    logic [1:0]          r_vld_pipe;
    logic                r_wen_d1;
    logic                r_run_d1;
    logic [DATA_W-1:0]   r_data_d1;
    logic [WIN_W-1:0]    r_win;
    logic                r_border;

    logic                w_pv, w_line_end, w_wen0;
    logic [DATA_W-1:0]   w_q0, w_q1;

    assign w_pv       = bus.iFVAL & bus.iDVAL;
    assign w_line_end = r_vld_pipe[0] & ~w_pv;
    // Once the last column has been written, further pixels of the line are not stored.
    assign w_wen0     = w_pv & ~r_full;

    // State register.
    always_ff @(posedge iCLK or negedge iRST_N)
        if (!iRST_N) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;

    // Next state: RUN once two full lines of history exist in the frame.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.iFVAL) w_state_nxt = ST_FILL;
            ST_FILL: if (w_line_end && r_row == 2'd1) w_state_nxt = ST_RUN;
            default: w_state_nxt = r_state;
        endcase
        if (!bus.iFVAL) w_state_nxt = ST_IDLE;
    end

    // Column/row counters and sticky overflow.
    always_ff @(posedge iCLK or negedge iRST_N)
        if (!iRST_N) begin
            r_col  <= '0;
            r_full <= 1'b0;
            r_row  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_pv && r_full) r_ovf <= 1'b1;
            if (!bus.iFVAL) begin
                r_col  <= '0;
                r_full <= 1'b0;
                r_row  <= '0;
            end else if (w_pv) begin
                if (r_col == COL_LAST) r_full <= 1'b1;
                else                   r_col  <= r_col + 1'b1;
            end else if (w_line_end) begin
                r_col  <= '0;
                r_full <= 1'b0;
                if (r_row != 2'd2) r_row <= r_row + 1'b1;
            end
        end

    // One-cycle alignment of the live pixel with the RAM read taps.
    always_ff @(posedge iCLK or negedge iRST_N)
        if (!iRST_N) begin
            r_vld_pipe <= '0;
            r_col_d1   <= '0;
            r_wen_d1   <= 1'b0;
            r_run_d1   <= 1'b0;
            r_data_d1  <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], w_pv};
            r_col_d1   <= r_col;
            r_wen_d1   <= w_wen0;
            r_run_d1   <= (r_state == ST_RUN);
            r_data_d1  <= bus.iDATA;
        end

    // Window shift: older columns move left, taps load into column 2; holds when idle.
    always_ff @(posedge iCLK or negedge iRST_N)
        if (!iRST_N) begin
            r_win    <= '0;
            r_border <= 1'b0;
        end else if (r_vld_pipe[0]) begin
            for (int r = 0; r < 3; r++) begin
                r_win[win_idx(r, 0) +: DATA_W] <= r_win[win_idx(r, 1) +: DATA_W];
                r_win[win_idx(r, 1) +: DATA_W] <= r_win[win_idx(r, 2) +: DATA_W];
            end
            r_win[win_idx(0, 2) +: DATA_W] <= w_q1;
            r_win[win_idx(1, 2) +: DATA_W] <= w_q0;
            r_win[win_idx(2, 2) +: DATA_W] <= r_data_d1;
            r_border <= ~r_run_d1 | (r_col_d1 < ADDR_W'(2));
        end

    // Previous line: written with the live pixel, read at the same column.
    line_ram_2p #(.DW(DATA_W), .DEPTH(MAX_WIDTH), .AW(ADDR_W)) u_ram0 (
        .iCLK    (iCLK),
        .i_wen   (w_wen0),
        .i_waddr (r_col),
        .i_wdata (bus.iDATA),
        .i_rden  (w_pv),
        .i_raddr (r_col),
        .o_rdata (w_q0)
    );

    // Two lines up: fed by RAM0's read data one cycle later (cascade).
    line_ram_2p #(.DW(DATA_W), .DEPTH(MAX_WIDTH), .AW(ADDR_W)) u_ram1 (
        .iCLK    (iCLK),
        .i_wen   (r_wen_d1),
        .i_waddr (r_col_d1),
        .i_wdata (w_q0),
        .i_rden  (w_pv),
        .i_raddr (r_col),
        .o_rdata (w_q1)
    );

    assign bus.oWIN    = r_win;
    assign bus.oDVAL   = r_vld_pipe[1];
    assign bus.oBORDER = r_border;
    assign bus.oOVF    = r_ovf;
endmodule

// File: tb/tb_line_window_3x3.sv
// Scoreboard bench for line_window_3x3: a line-history model predicts each window.
module tb_line_window_3x3;
    import line_window_3x3_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   nb0 = 0;

    line_window_3x3_if bus();

    line_window_3x3 dut (.iCLK(clk), .iRST_N(rst_n), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIN_W-1:0] win;
        logic [WIN_W-1:0] mask;
        logic             border;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic [WIN_W-1:0] last_win, last_mask;

    // Model state: line history with "known" flags (RAM is not cleared by reset).
    logic [DATA_W-1:0] m0 [MAX_WIDTH];
    logic [DATA_W-1:0] m1 [MAX_WIDTH];
    bit                m0k [MAX_WIDTH];
    bit                m1k [MAX_WIDTH];
    logic [DATA_W-1:0] mw [9];
    bit                mk [9];
    int                mrow, mcol;
    bit                mfull, minl;

    task automatic chk(input string tag, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < MAX_WIDTH; i++) begin
            m0k[i] = 1'b0;
            m1k[i] = 1'b0;
        end
        for (int e = 0; e < 9; e++) begin
            mw[e] = '0;
            mk[e] = 1'b1;
        end
        mrow = 0; mcol = 0; mfull = 1'b0; minl = 1'b0;
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        exp_t e;
        logic [DATA_W-1:0] t0, t1;
        bit k0, k1;
        int c;
        c  = mcol;
        t1 = m0[c]; k1 = m0k[c];
        t0 = m1[c]; k0 = m1k[c];
        if (!mfull) begin
            m1[c] = t1; m1k[c] = k1;
            m0[c] = d;  m0k[c] = 1'b1;
        end
        for (int r = 0; r < 3; r++) begin
            mw[r*3]   = mw[r*3+1]; mk[r*3]   = mk[r*3+1];
            mw[r*3+1] = mw[r*3+2]; mk[r*3+1] = mk[r*3+2];
        end
        mw[2] = t0; mk[2] = k0;
        mw[5] = t1; mk[5] = k1;
        mw[8] = d;  mk[8] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            e.win[i*DATA_W +: DATA_W]  = mw[i];
            e.mask[i*DATA_W +: DATA_W] = {DATA_W{mk[i]}};
        end
        e.border = (mrow < 2) || (c < 2);
        e.cyc    = cyc;
        sb.push_back(e);
        if (!mfull) begin
            if (c == MAX_WIDTH - 1) mfull = 1'b1;
            else                    mcol++;
        end
        minl = 1'b1;
    endtask

    task automatic px(input logic [DATA_W-1:0] d);
        @(negedge clk);
        bus.iDVAL = 1'b1;
        bus.iDATA = d;
        push(d);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.iDVAL = 1'b0;
            if (minl) begin
                minl = 1'b0; mcol = 0; mfull = 1'b0;
                if (mrow < 2) mrow++;
            end
        end
    endtask

    task automatic frm_on();
        @(negedge clk);
        bus.iFVAL = 1'b1;
    endtask

    task automatic frm_off();
        @(negedge clk);
        bus.iFVAL = 1'b0;
        bus.iDVAL = 1'b0;
        mrow = 0; mcol = 0; mfull = 1'b0; minl = 1'b0;
        @(negedge clk);
    endtask

    task automatic drained(input string tag);
        chk(tag, WIN_W'(sb.size()), WIN_W'(0));
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.iDVAL = 1'b0;
        bus.iFVAL = 1'b0;
        #1;
        chk({tag, "_win"},    bus.oWIN,    '0);
        chk({tag, "_dval"},   WIN_W'(bus.oDVAL),   '0);
        chk({tag, "_border"}, WIN_W'(bus.oBORDER), '0);
        chk({tag, "_ovf"},    WIN_W'(bus.oOVF),    '0);
        sb.delete();
        m_reset();
        last_win = '0; last_mask = '1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Output monitor: pop and compare on every window; check hold on idle cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_win  = '0;
            last_mask = '1;
        end else if (bus.oDVAL) begin
            if (!bus.oBORDER) nb0++;
            if (sb.size() == 0) begin
                chk("unexpected_dval", WIN_W'(1), WIN_W'(0));
            end else begin
                mon_e = sb.pop_front();
                chk("latency", WIN_W'(cyc - mon_e.cyc), WIN_W'(2));
                chk("win",     bus.oWIN & mon_e.mask, mon_e.win & mon_e.mask);
                chk("border",  WIN_W'(bus.oBORDER), WIN_W'(mon_e.border));
                last_win  = mon_e.win;
                last_mask = mon_e.mask;
            end
        end else begin
            chk("hold", bus.oWIN & last_mask, last_win & last_mask);
        end
    end

    initial begin
        logic [WIN_W-1:0] w, expw;
        rst_n = 1'b0;
        bus.iFVAL = 1'b0; bus.iDVAL = 1'b0; bus.iDATA = '0;
        m_reset();
        last_win = '0; last_mask = '1;
        repeat (2) @(negedge clk);
        chk("rst_win",    bus.oWIN, '0);
        chk("rst_dval",   WIN_W'(bus.oDVAL),   '0);
        chk("rst_border", WIN_W'(bus.oBORDER), '0);
        chk("rst_ovf",    WIN_W'(bus.oOVF),    '0);
        @(negedge clk);
        rst_n = 1'b1;

        // 3 lines x 4 pixels, value = row*16+col.
        nb0 = 0;
        frm_on();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) px(DATA_W'(r * 16 + c));
            gap(2);
        end
        gap(2);
        drained("fa_drain");
        chk("fa_nb0", WIN_W'(nb0), WIN_W'(2));
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) expw[win_idx(r, c) +: DATA_W] = DATA_W'(r * 16 + c + 1);
        chk("fa_lastwin", bus.oWIN, expw);
        frm_off();

        // Pixels outside a frame are ignored.
        repeat (3) begin
            @(negedge clk);
            bus.iDVAL = 1'b1; bus.iDATA = 10'h2AA;
        end
        @(negedge clk);
        bus.iDVAL = 1'b0;
        gap(3);

        // New frame with a 5-cycle gap mid-frame; row restarts, col restarts.
        frm_on();
        for (int c = 0; c < 4; c++) px(DATA_W'(256 + c));
        gap(5);
        for (int c = 0; c < 4; c++) px(DATA_W'(272 + c));
        gap(2);
        for (int c = 0; c < 4; c++) px(DATA_W'(288 + c));
        gap(3);
        drained("fb_drain");
        frm_off();

        // Single-pixel latency pulse.
        frm_on();
        gap(1);
        px(10'h3FF);
        gap(4);
        drained("lat_drain");
        chk("lat_c2r2", WIN_W'(bus.oWIN[win_idx(2, 2) +: DATA_W]), WIN_W'(10'h3FF));
        frm_off();

        // Reset in the middle of a line.
        frm_on();
        px(10'd1); px(10'd2); px(10'd3);
        do_reset("midrst");
        frm_on();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 3; c++) px(DATA_W'(512 + r * 16 + c));
            gap(2);
        end
        gap(2);
        drained("fc_drain");
        frm_off();

        // Full-width ramp lines, then one over-long line.
        frm_on();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < MAX_WIDTH; c++) px(DATA_W'(c));
            gap(2);
        end
        gap(2);
        drained("wide_drain");
        chk("wide_noovf", WIN_W'(bus.oOVF), '0);
        w = bus.oWIN;
        chk("wide_c2", WIN_W'({w[win_idx(0, 2) +: DATA_W], w[win_idx(1, 2) +: DATA_W], w[win_idx(2, 2) +: DATA_W]}),
            WIN_W'({10'd1279, 10'd1279, 10'd1279}));
        for (int c = 0; c < MAX_WIDTH; c++) px(DATA_W'((c * 3) & 1023));
        px(10'h155);
        gap(3);
        chk("ovf_set", WIN_W'(bus.oOVF), WIN_W'(1));
        for (int c = 0; c < MAX_WIDTH; c++) px(10'd0);
        gap(3);
        drained("ovf_drain");
        w = bus.oWIN;
        chk("ovf_keep1279", WIN_W'({w[win_idx(0, 2) +: DATA_W], w[win_idx(1, 2) +: DATA_W], w[win_idx(2, 2) +: DATA_W]}),
            WIN_W'({10'd1279, 10'((1279 * 3) & 1023), 10'd0}));
        chk("ovf_sticky", WIN_W'(bus.oOVF), WIN_W'(1));
        frm_off();

        do_reset("endrst");
        gap(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/line_window_3x3.md
Name: line_window_3x3

Overview:
- Converts the raster pixel stream from CCD capture into a 3x3 neighbourhood window for the Sobel edge stage.
- Holds two previous lines in two cascaded 1280x10 line RAMs with a registered read port.
- Aligns the current pixel with the RAM taps and shifts the taps into a 3x3 register window.
- Flags windows that touch the top or left frame border so the edge stage can zero them.

Parameters:
- DATA_W, 10, pixel width
- MAX_WIDTH, 1280, maximum pixels per line (line RAM depth)
- ADDR_W, 11, line RAM address width (ceil log2 MAX_WIDTH)

Ports:
- iCLK  in  1  pixel clock; all logic on rising edge
- iRST_N  in  1  asynchronous active-low reset
- iFVAL  in  1  frame valid; low between frames
- iDVAL  in  1  pixel valid; contiguous high run = one line
- iDATA  in  DATA_W  pixel
- oWIN  out  9*DATA_W  window; index (r*3+c)*DATA_W; r0 = two lines up, r2 = current line; c2 = newest column
- oDVAL  out  1  window valid
- oBORDER  out  1  window includes rows 0-1 or columns 0-1 of the frame
- oOVF  out  1  sticky: a line exceeded MAX_WIDTH pixels

Behaviour:
- Reset (async, iRST_N=0): oWIN=0, oDVAL=0, oBORDER=0, oOVF=0. Column, row and state registers clear. RAM contents are not cleared.
- States:
  - IDLE: iFVAL=0.
  - FILL: iFVAL=1 and row<2.
  - RUN: row>=2.
  - IDLE->FILL on iFVAL=1. FILL->RUN when the second line ends. Any state->IDLE when iFVAL=0; row clears to 0.
- Column counter col:
  - Increments on each iDVAL=1 cycle.
  - Clears on the iDVAL falling edge (line end). Row increments at the same edge, saturating at 2.
  - Saturates at MAX_WIDTH-1. When iDVAL=1 and col=MAX_WIDTH-1 has already been used, RAM writes are suppressed, oOVF sets, and the window still shifts.
- Cycle t (iDVAL=1):
  - RAM0 write addr=col, data=iDATA.
  - RAM0 and RAM1 read addr=col.
  - Same-address read/write returns OLD data.
- Cycle t+1:
  - tap2 = iDATA delayed 1; tap1 = RAM0.q; tap0 = RAM1.q.
  - RAM1 write addr=col_d1, data=RAM0.q. This cascade builds the line-2 history.
- Cycle t+2:
  - oWIN columns shift left; column 2 loads {tap0,tap1,tap2}.
  - oDVAL = iDVAL delayed 2.
  - oBORDER = (row_d2<2) | (col_d2<2).
- Latency: fixed 2 cycles from iDVAL/iDATA to oDVAL/oWIN column 2.
- oWIN holds its value when oDVAL=0. No shifting on idle cycles.
- iDVAL=1 while iFVAL=0: pixel ignored. No RAM write, no oDVAL.
- Reset mid-line: outputs drop immediately. Stale RAM data after reset is covered by oBORDER, because row restarts at 0.
- Lines shorter than the previous line: only the written columns are valid. Columns beyond are never read in that line.
- oOVF clears only by reset.

Decomposition:
- Shared package (image pipeline): DATA_W, MAX_WIDTH, ADDR_W, window index helper constants (WIN_IDX(r,c)).
- Sub-module line_ram_2p: single clock, one write port, one registered read port with rden, old-data on same-address collision. Instantiated twice.
- Counters, FSM, delay alignment and window registers live in the top module.

Test Plan:
- Reset mid-stream: assert iRST_N=0 during a line -> all outputs 0 the same cycle. After release, the first window of the next frame has oBORDER=1.
- Frame of 3 lines x 4 pixels, pixel value = row*16+col:
  - In line 2, the 4th oDVAL shows oWIN row0 = {1,2,3}, row1 = {17,18,19}, row2 = {33,34,35}.
  - oBORDER=0 only for columns 2-3 of row 2.
- Latency: single pixel pulse iDATA=0x3FF -> oDVAL exactly 2 cycles later, with oWIN column 2 row 2 = 0x3FF.
- Line width 1280 with a ramp 0..1279 across 3 lines:
  - The last window's column 2 = {1279,1279,1279}.
  - No oOVF.
  - A 1281-pixel line sets oOVF=1 and leaves RAM address 1279 unchanged.
- Frame gap: drop iFVAL between two frames -> row restarts at 0. The first two lines of the new frame have oBORDER=1 on every oDVAL.
- Gap cycles: iDVAL=0 for 5 cycles mid-frame, then a new line -> oWIN unchanged during the gap, and col restarts at 0.
